// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine change dispenser.
// Coin values are kept in won to match the machine's 16-bit credit encoding.
package vm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_SEL     = 3'd2,
        ST_PAY1000 = 3'd3,
        ST_PAY500  = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_AMOUNT  = 2'b01;
    localparam logic [1:0] ERR_COINS   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [15:0] COIN_500_WON  = 16'd500;
    localparam logic [15:0] COIN_1000_WON = 16'd1000;

    localparam logic [4:0] MAX_AMOUNT_U = 5'd10;

    // Owed amounts travel in 500-won units; this maps a coin value onto that unit.
    function automatic logic [4:0] won_to_units(input logic [15:0] won);
        return 5'(won / COIN_500_WON);
    endfunction

endpackage

// File: rtl/vm_coin_counter.sv
// 8-bit saturating inventory counter for one coin denomination.
// Simultaneous increment and decrement cancel out.
module vm_coin_counter
#(
    parameter logic [7:0] INIT_COUNT = 8'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [7:0] o_count
);
    logic [7:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= INIT_COUNT;
        end else if (i_inc && !i_dec) begin
            if (r_count != 8'hFF) r_count <= r_count + 8'd1;
        end else if (i_dec && !i_inc) begin
            if (r_count != 8'h00) r_count <= r_count - 8'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vm_change_dispenser.sv
// Pays owed 500-won units with 1000/500 coins through a one-coin hopper handshake.
// Flow: IDLE -> CHECK -> SEL <-> PAY1000/PAY500 -> DONE; any failure exits through ERR.
module vm_change_dispenser
    import vm_pkg::*;
#(
    parameter logic [7:0] INIT_COUNT = 8'd10,
    parameter logic [7:0] TIMEOUT    = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] amount_u,
    input  logic       hop_ack,
    input  logic       refill_1000,
    input  logic       refill_500,
    output logic       change_1000,
    output logic       change_500,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [4:0] rem_u,
    output logic [7:0] cnt_1000,
    output logic [7:0] cnt_500
);
    localparam logic [4:0] UNITS_1000 = won_to_units(COIN_1000_WON);
    localparam logic [4:0] UNITS_500  = won_to_units(COIN_500_WON);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_rem_u;
    logic [7:0] r_wait;
    logic [7:0] w_wait_nxt;
    logic [1:0] r_err_code;
    logic [1:0] w_err_code_nxt;
    logic       r_change_1000;
    logic       r_change_500;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic       w_in_pay;
    logic       w_ack_1000;
    logic       w_ack_500;
    logic       w_timeout;
    logic [7:0] w_half;
    logic [7:0] w_n1000;
    logic [7:0] w_need500;

    assign w_in_pay   = (r_state == ST_PAY1000) || (r_state == ST_PAY500);
    assign w_ack_1000 = (r_state == ST_PAY1000) && hop_ack;
    assign w_ack_500  = (r_state == ST_PAY500) && hop_ack;
    assign w_wait_nxt = r_wait + 8'd1;
    assign w_timeout  = w_in_pay && !hop_ack && (w_wait_nxt == TIMEOUT);

    // Greedy split: as many 1000s as are owed and stocked, the rest in 500s.
    assign w_half    = {4'b0000, r_rem_u[4:1]};
    assign w_n1000   = (w_half < cnt_1000) ? w_half : cnt_1000;
    assign w_need500 = {3'b000, r_rem_u} - {w_n1000[6:0], 1'b0};

    vm_coin_counter #(.INIT_COUNT(INIT_COUNT)) u_cnt_1000 (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (refill_1000),
        .i_dec   (w_ack_1000),
        .o_count (cnt_1000)
    );

    vm_coin_counter #(.INIT_COUNT(INIT_COUNT)) u_cnt_500 (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (refill_500),
        .i_dec   (w_ack_500),
        .o_count (cnt_500)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = r_err_code;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt    = ST_CHECK;
                    w_err_code_nxt = ERR_NONE;
                end
            end
            ST_CHECK: begin
                if (r_rem_u > MAX_AMOUNT_U) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_AMOUNT;
                end else if (w_need500 > cnt_500) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_COINS;
                end else if (r_rem_u == 5'd0) begin
                    // Nothing owed: skip SEL so done lands two cycles after start.
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SEL;
                end
            end
            ST_SEL: begin
                if (r_rem_u == 5'd0)                               w_state_nxt = ST_DONE;
                else if ((r_rem_u >= UNITS_1000) && (cnt_1000 != 8'd0)) w_state_nxt = ST_PAY1000;
                else                                               w_state_nxt = ST_PAY500;
            end
            ST_PAY1000, ST_PAY500: begin
                if (hop_ack) begin
                    w_state_nxt = ST_SEL;
                end else if (w_timeout) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_TIMEOUT;
                end
            end
            ST_DONE, ST_ERR: w_state_nxt = ST_IDLE;
            default:         w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem_u       <= 5'd0;
            r_wait        <= 8'd0;
            r_err_code    <= ERR_NONE;
            r_change_1000 <= 1'b0;
            r_change_500  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_err_code    <= w_err_code_nxt;
            r_change_1000 <= (w_state_nxt == ST_PAY1000);
            r_change_500  <= (w_state_nxt == ST_PAY500);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_done        <= (w_state_nxt == ST_DONE);
            r_err         <= (w_state_nxt == ST_ERR);
            if ((r_state == ST_IDLE) && start) r_rem_u <= amount_u;
            else if (w_ack_1000)               r_rem_u <= r_rem_u - UNITS_1000;
            else if (w_ack_500)                r_rem_u <= r_rem_u - UNITS_500;
            r_wait <= w_in_pay ? w_wait_nxt : 8'd0;
        end
    end

    assign change_1000 = r_change_1000;
    assign change_500  = r_change_500;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign rem_u       = r_rem_u;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser with a coin-level inventory model
// and a per-cycle inventory/exclusivity monitor.
module tb_vm_change_dispenser;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] amount_u;
    logic       hop_ack;
    logic       refill_1000;
    logic       refill_500;
    logic       change_1000;
    logic       change_500;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [4:0] rem_u;
    logic [7:0] cnt_1000;
    logic [7:0] cnt_500;

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt1000 = 10;
    int m_cnt500  = 10;
    int ack_kind  = 0;   // 1: bench is acking a 1000 coin, 2: a 500 coin

    vm_change_dispenser #(.INIT_COUNT(8'd10), .TIMEOUT(8'd8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .amount_u    (amount_u),
        .hop_ack     (hop_ack),
        .refill_1000 (refill_1000),
        .refill_500  (refill_500),
        .change_1000 (change_1000),
        .change_500  (change_500),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .rem_u       (rem_u),
        .cnt_1000    (cnt_1000),
        .cnt_500     (cnt_500)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inventory after one clock: add refills, remove paid coins, clamp to 0..255.
    function automatic int step_cnt(input int c, input bit inc, input bit dec);
        int n;
        n = c + int'(inc) - int'(dec);
        if (n > 255) n = 255;
        if (n < 0)   n = 0;
        return n;
    endfunction

    // Expected outcome of a request: error code and how many coins of each kind.
    function automatic void plan(input int amt, input int c1000, input int c500,
                                 output int code, output int n1k, output int n5);
        n1k  = 0;
        n5   = 0;
        code = 0;
        if (amt > 10) begin
            code = 1;
        end else begin
            n1k = (amt / 2 < c1000) ? amt / 2 : c1000;
            n5  = amt - 2 * n1k;
            if (n5 > c500) begin
                code = 2;
                n1k  = 0;
                n5   = 0;
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt1000 <= 10;
            m_cnt500  <= 10;
        end else begin
            m_cnt1000 <= step_cnt(m_cnt1000, refill_1000, hop_ack && (ack_kind == 1));
            m_cnt500  <= step_cnt(m_cnt500, refill_500, hop_ack && (ack_kind == 2));
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("mon_cnt_1000", cnt_1000, m_cnt1000);
            chk("mon_cnt_500", cnt_500, m_cnt500);
            chk("mon_one_coin_max", change_1000 & change_500, 1'b0);
        end
    end

    task automatic wait_coin(output int got);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (change_1000 || change_500) break;
            @(negedge clk);
        end
        if (change_1000)     got = 1;
        else if (change_500) got = 2;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pay_txn(input int amt, input int ack_dly, input bit refill_on_500,
                           output int done_wait);
        int code, n1k, n5, got, want;
        plan(amt, m_cnt1000, m_cnt500, code, n1k, n5);
        done_wait = -1;
        @(negedge clk);
        start    = 1'b1;
        amount_u = amt[4:0];
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_check", busy, 1'b1);
        chk("rem_latched", rem_u, amt);
        chk("no_coin_in_check", {change_1000, change_500}, 2'b00);
        if (code != 0) begin
            @(negedge clk);
            chk("err_pulse", err, 1'b1);
            chk("err_code", err_code, code);
            chk("err_no_coin", {change_1000, change_500}, 2'b00);
            chk("err_no_done", done, 1'b0);
            @(negedge clk);
            chk("err_one_cycle", err, 1'b0);
            chk("idle_after_err", busy, 1'b0);
            chk("err_code_hold", err_code, code);
        end else begin
            for (int k = 0; k < n1k + n5; k++) begin
                want = (k < n1k) ? 1 : 2;
                wait_coin(got);
                chk("coin_kind", got, want);
                for (int d = 1; d < ack_dly; d++) begin
                    @(negedge clk);
                    chk("coin_held", (want == 1) ? change_1000 : change_500, 1'b1);
                end
                hop_ack  = 1'b1;
                ack_kind = want;
                if (want == 2 && refill_on_500) refill_500 = 1'b1;
                @(negedge clk);
                hop_ack    = 1'b0;
                ack_kind   = 0;
                refill_500 = 1'b0;
                chk("coin_dropped", {change_1000, change_500}, 2'b00);
            end
            for (int i = 0; i < 10; i++) begin
                if (done) begin
                    done_wait = i;
                    break;
                end
                @(negedge clk);
            end
            chk("done_pulse", done, 1'b1);
            chk("done_no_err", err, 1'b0);
            chk("done_rem_zero", rem_u, 5'd0);
            chk("done_err_code", err_code, 2'b00);
            chk("done_no_coin", {change_1000, change_500}, 2'b00);
            @(negedge clk);
            chk("done_one_cycle", done, 1'b0);
            chk("idle_after_done", busy, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time %0t, expected completion before 100000", $time);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, got, hi, pulses;
        reset       = 1'b0;
        start       = 1'b0;
        amount_u    = 5'd0;
        hop_ack     = 1'b0;
        refill_1000 = 1'b0;
        refill_500  = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_coins", {change_1000, change_500}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done_err", {done, err}, 2'b00);
        chk("rst_err_code", err_code, 2'b00);
        chk("rst_rem", rem_u, 5'd0);
        chk("rst_cnt_1000", cnt_1000, 8'd10);
        chk("rst_cnt_500", cnt_500, 8'd10);
        @(negedge clk);
        reset = 1'b0;

        // Acknowledge while idle must not touch inventory.
        @(negedge clk);
        hop_ack = 1'b1;
        @(negedge clk);
        hop_ack = 1'b0;
        chk("stray_ack_busy", busy, 1'b0);
        chk("stray_ack_cnt_1000", cnt_1000, 8'd10);

        pay_txn(7, 2, 1'b0, w);
        chk("amt7_cnt_1000", cnt_1000, 8'd7);
        chk("amt7_cnt_500", cnt_500, 8'd9);

        pay_txn(0, 1, 1'b0, w);
        chk("amt0_done_latency", w, 1);

        pay_txn(12, 1, 1'b0, w);
        pay_txn(11, 1, 1'b0, w);

        // Drain to 1/1, then a request that needs more 500s than stocked.
        pulse_reset();
        pay_txn(10, 1, 1'b0, w);
        chk("drain_cnt_1000_a", cnt_1000, 8'd5);
        pay_txn(10, 1, 1'b0, w);
        pay_txn(9, 1, 1'b0, w);
        @(negedge clk);
        refill_1000 = 1'b1;
        @(negedge clk);
        refill_1000 = 1'b0;
        chk("drained_cnt_1000", cnt_1000, 8'd1);
        chk("drained_cnt_500", cnt_500, 8'd1);
        pay_txn(4, 1, 1'b0, w);
        chk("short_cnt_1000", cnt_1000, 8'd1);
        chk("short_cnt_500", cnt_500, 8'd1);

        // Hopper never answers: 8-cycle wait then timeout error.
        pulse_reset();
        @(negedge clk);
        start    = 1'b1;
        amount_u = 5'd2;
        @(negedge clk);
        start = 1'b0;
        wait_coin(got);
        chk("to_coin_kind", got, 1);
        hi = 0;
        while (change_1000 && hi < 30) begin
            hi++;
            @(negedge clk);
        end
        chk("to_hold_cycles", hi, 8);
        chk("to_err", err, 1'b1);
        chk("to_err_code", err_code, 2'b11);
        chk("to_rem", rem_u, 5'd2);
        chk("to_cnt_1000", cnt_1000, 8'd10);
        @(negedge clk);
        chk("to_err_code_hold", err_code, 2'b11);
        chk("to_idle", busy, 1'b0);

        // Refill in the same cycle as a 500 payment.
        pay_txn(1, 1, 1'b1, w);
        chk("refill_ack_cnt_500", cnt_500, 8'd10);

        @(negedge clk);
        refill_1000 = 1'b1;
        refill_500  = 1'b1;
        repeat (250) @(negedge clk);
        refill_1000 = 1'b0;
        refill_500  = 1'b0;
        chk("sat_cnt_1000", cnt_1000, 8'd255);
        chk("sat_cnt_500", cnt_500, 8'd255);

        // Reset in the middle of a 500 payment.
        @(negedge clk);
        start    = 1'b1;
        amount_u = 5'd1;
        @(negedge clk);
        start = 1'b0;
        wait_coin(got);
        chk("rp_coin_kind", got, 2);
        #2 reset = 1'b1;
        #1;
        chk("rp_change_500", change_500, 1'b0);
        chk("rp_busy", busy, 1'b0);
        chk("rp_rem", rem_u, 5'd0);
        chk("rp_cnt_1000", cnt_1000, 8'd10);
        chk("rp_cnt_500", cnt_500, 8'd10);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || err || change_500) pulses++;
        end
        chk("rp_no_pulse", pulses, 0);
        chk("rp_idle", busy, 1'b0);

        pay_txn(3, 1, 1'b0, w);
        chk("final_cnt_1000", cnt_1000, 8'd9);
        chk("final_cnt_500", cnt_500, 8'd9);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
